miter_cmp_monitor: RTL and testbench

MITER_CMP_MONITOR -- requirements
Module: miter_cmp_monitor

---
 rtl/miter_cmp_monitor.sv | 112 +++++++++++
 tb/tb_miter_cmp_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/miter_cmp_monitor.sv
// miter_cmp_monitor: masked gold-vs-gate comparator with run FSM, saturating counters and first-failure capture.
// Define MITER_CAPTURE_EN to add cap_gold/cap_gate, which latch the first mismatching sample.
module miter_cmp_monitor #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW          = CHANNELS * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             stop,
  input  logic             valid,
  input  logic [DW-1:0]    in_gold,
  input  logic [DW-1:0]    in_gate,
  input  logic [DW-1:0]    care,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             pass,
  output logic [CH_W-1:0]  first_ch,
  output logic [CNT_W-1:0] first_idx,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count
`ifdef MITER_CAPTURE_EN
  ,
  output logic [DW-1:0]    cap_gold,
  output logic [DW-1:0]    cap_gate
`endif
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, S_FAIL = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [CHANNELS-1:0] ch_mis;
  logic [CH_W-1:0] fch_c, fch_q, fch_d;
  logic [CNT_W-1:0] fidx_q, fidx_d, sc_q, sc_d, ec_q, ec_d;
  logic mm_q, mm_d, cmp, bad, capture;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch_mis[c] = |((in_gold[c*WIDTH +: WIDTH] ^ in_gate[c*WIDTH +: WIDTH]) & care[c*WIDTH +: WIDTH]);
  end
  always_comb begin
    fch_c = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (ch_mis[c]) fch_c = CH_W'(c);
  end
  // arm restarts the run, so a sample arriving with it is never compared
  assign cmp = valid && !arm && (state_q == ARMED || (state_q == S_FAIL && STOP_ON_FAIL == 0));
  assign bad = cmp && |ch_mis;
  assign capture = bad && !mm_q;
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    ec_d    = ec_q;
    mm_d    = mm_q;
    fch_d   = fch_q;
    fidx_d  = fidx_q;
    if (arm) begin
      state_d = ARMED;
      sc_d    = '0;
      ec_d    = '0;
      mm_d    = 1'b0;
      fch_d   = '0;
      fidx_d  = '0;
    end else begin
      sc_d   = cmp ? ((&sc_q) ? sc_q : sc_q + CNT_W'(1)) : sc_q;
      ec_d   = bad ? ((&ec_q) ? ec_q : ec_q + CNT_W'(1)) : ec_q;
      mm_d   = mm_q | bad;
      fch_d  = capture ? fch_c : fch_q;
      fidx_d = capture ? sc_q : fidx_q;
      state_d = bad ? S_FAIL : state_q;
      if (stop && (state_q == ARMED || state_q == S_FAIL)) state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      ec_q    <= '0;
      mm_q    <= 1'b0;
      fch_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      ec_q    <= ec_d;
      mm_q    <= mm_d;
      fch_q   <= fch_d;
      fidx_q  <= fidx_d;
    end
  end
`ifdef MITER_CAPTURE_EN
  logic [DW-1:0] cg_q, ct_q;
  always_ff @(posedge clk) begin
    if (!rst || arm) begin
      cg_q <= '0;
      ct_q <= '0;
    end else if (capture) begin
      cg_q <= in_gold;
      ct_q <= in_gate;
    end
  end
  assign cap_gold = cg_q;
  assign cap_gate = ct_q;
`endif
  assign state        = state_q;
  assign mismatch     = mm_q;
  assign pass         = (state_q == DONE) && (ec_q == '0);
  assign first_ch     = fch_q;
  assign first_idx    = fidx_q;
  assign sample_count = sc_q;
  assign err_count    = ec_q;
endmodule

// File: tb/tb_miter_cmp_monitor.sv
// tb_miter_cmp_monitor: table-driven directed checks of the miter monitor, plus saturation and capture sequences.
module tb_miter_cmp_monitor;
  logic clk = 1'b0;
  logic rst, arm, stop, valid;
  logic [31:0] gold, gate, care;
  logic [1:0] st1, st2;
  logic mm1, ps1, mm2, ps2;
  logic [1:0] fch1, fch2;
  logic [15:0] fidx1, sc1, ec1;
  logic [1:0] fidx2, sc2, ec2;
`ifdef MITER_CAPTURE_EN
  logic [31:0] cg1, ct1, cg2, ct2;
`endif
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  miter_cmp_monitor dut1 (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .valid(valid),
    .in_gold(gold), .in_gate(gate), .care(care),
    .state(st1), .mismatch(mm1), .pass(ps1), .first_ch(fch1),
    .first_idx(fidx1), .sample_count(sc1), .err_count(ec1)
`ifdef MITER_CAPTURE_EN
    , .cap_gold(cg1), .cap_gate(ct1)
`endif
  );

  miter_cmp_monitor #(.CNT_W(2), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .valid(valid),
    .in_gold(gold), .in_gate(gate), .care(care),
    .state(st2), .mismatch(mm2), .pass(ps2), .first_ch(fch2),
    .first_idx(fidx2), .sample_count(sc2), .err_count(ec2)
`ifdef MITER_CAPTURE_EN
    , .cap_gold(cg2), .cap_gate(ct2)
`endif
  );

  typedef struct {
    logic rs, a, s, v;
    logic [31:0] g, t, c;
    logic [1:0] st;
    logic mm, ps;
    logic [1:0] fch;
    logic [15:0] fidx, sc, ec;
  } vec_t;
  vec_t vt[23];

  function automatic vec_t mk(logic rs, logic a, logic s, logic v, logic [31:0] g, logic [31:0] t, logic [31:0] c,
                              logic [1:0] st, logic mm, logic ps, logic [1:0] fch, logic [15:0] fidx,
                              logic [15:0] sc, logic [15:0] ec);
    mk = '{rs, a, s, v, g, t, c, st, mm, ps, fch, fidx, sc, ec};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic a, input logic s, input logic v,
                      input logic [31:0] g, input logic [31:0] t, input logic [31:0] c);
    @(negedge clk);
    rst = r; arm = a; stop = s; valid = v; gold = g; gate = t; care = c;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; arm = 1'b0; stop = 1'b0; valid = 1'b0; gold = '0; gate = '0; care = FF;
    vt[0]  = mk(0,0,0,0, 32'h0,        32'h0,        FF,           0,0,0,0,0,0,0);
    vt[1]  = mk(1,0,1,0, 32'h0,        32'h0,        FF,           0,0,0,0,0,0,0);
    vt[2]  = mk(1,0,0,1, 32'h1,        32'h0,        FF,           0,0,0,0,0,0,0);
    vt[3]  = mk(1,1,0,1, 32'h1,        32'h0,        FF,           1,0,0,0,0,0,0);
    vt[4]  = mk(1,0,0,1, 32'hA5A5A5A5, 32'hA5A5A5A5, FF,           1,0,0,0,0,1,0);
    vt[5]  = mk(1,0,0,0, 32'h1,        32'h0,        FF,           1,0,0,0,0,1,0);
    vt[6]  = mk(1,0,0,1, 32'h5A5A5A5A, 32'h5A5A5A5A, FF,           1,0,0,0,0,2,0);
    vt[7]  = mk(1,0,0,1, 32'h0,        32'hF0,       32'h0000000F, 1,0,0,0,0,3,0);
    vt[8]  = mk(1,0,0,1, 32'h12345678, 32'h02045678, FF,           2,1,0,2,3,4,1);
    vt[9]  = mk(1,0,0,1, 32'h0,        32'h1,        FF,           2,1,0,2,3,4,1);
    vt[10] = mk(1,0,1,1, 32'h0,        32'h1,        FF,           3,1,0,2,3,4,1);
    vt[11] = mk(1,0,1,1, 32'h0,        32'h1,        FF,           3,1,0,2,3,4,1);
    vt[12] = mk(1,1,0,0, 32'h0,        32'h0,        FF,           1,0,0,0,0,0,0);
    vt[13] = mk(1,0,0,1, 32'h0000FF00, 32'h0,        FF,           2,1,0,1,0,1,1);
    vt[14] = mk(1,1,1,1, 32'h0,        32'h1,        FF,           1,0,0,0,0,0,0);
    vt[15] = mk(1,0,0,1, 32'h7,        32'h7,        FF,           1,0,0,0,0,1,0);
    vt[16] = mk(1,0,1,1, 32'h1,        32'h0,        FF,           3,1,0,0,1,2,1);
    vt[17] = mk(1,1,0,0, 32'h0,        32'h0,        FF,           1,0,0,0,0,0,0);
    vt[18] = mk(1,0,0,1, 32'h80000000, 32'h0,        FF,           2,1,0,3,0,1,1);
    vt[19] = mk(0,1,1,1, 32'h1,        32'h0,        FF,           0,0,0,0,0,0,0);
    vt[20] = mk(1,1,0,0, 32'h0,        32'h0,        FF,           1,0,0,0,0,0,0);
    vt[21] = mk(1,0,0,1, 32'h3,        32'h3,        FF,           1,0,0,0,0,1,0);
    vt[22] = mk(1,0,1,1, FF,           32'h0,        32'h0,        3,0,1,0,0,2,0);
    for (int i = 0; i < 23; i++) begin
      step(vt[i].rs, vt[i].a, vt[i].s, vt[i].v, vt[i].g, vt[i].t, vt[i].c);
      chk($sformatf("v%0d state", i), 32'(st1), 32'(vt[i].st));
      chk($sformatf("v%0d mismatch", i), 32'(mm1), 32'(vt[i].mm));
      chk($sformatf("v%0d pass", i), 32'(ps1), 32'(vt[i].ps));
      chk($sformatf("v%0d first_ch", i), 32'(fch1), 32'(vt[i].fch));
      chk($sformatf("v%0d first_idx", i), 32'(fidx1), 32'(vt[i].fidx));
      chk($sformatf("v%0d sample_count", i), 32'(sc1), 32'(vt[i].sc));
      chk($sformatf("v%0d err_count", i), 32'(ec1), 32'(vt[i].ec));
    end

    // ten matching samples then stop
    step(1, 1, 0, 0, 0, 0, FF);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 32'h01010101 * i, 32'h01010101 * i, FF);
    step(1, 0, 1, 0, 0, 0, FF);
    chk("run10 state", 32'(st1), 32'd3);
    chk("run10 sample_count", 32'(sc1), 32'd10);
    chk("run10 err_count", 32'(ec1), 32'd0);
    chk("run10 pass", 32'(ps1), 32'd1);
    chk("run10 mismatch", 32'(mm1), 32'd0);

    // keep-counting instance with 2-bit counters saturates
    step(0, 0, 0, 0, 0, 0, FF);
    step(1, 1, 0, 0, 0, 0, FF);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 32'(i + 1), 32'h0, FF);
    chk("sat err_count", 32'(ec2), 32'd3);
    chk("sat sample_count", 32'(sc2), 32'd3);
    chk("sat first_idx", 32'(fidx2), 32'd0);
    chk("sat first_ch", 32'(fch2), 32'd0);
    chk("sat state", 32'(st2), 32'd2);
    chk("sat mismatch", 32'(mm2), 32'd1);
    chk("frozen err_count", 32'(ec1), 32'd1);
    chk("frozen sample_count", 32'(sc1), 32'd1);
    step(1, 0, 1, 0, 0, 0, FF);
    chk("sat done state", 32'(st2), 32'd3);
    chk("sat done pass", 32'(ps2), 32'd0);

`ifdef MITER_CAPTURE_EN
    step(1, 1, 0, 0, 0, 0, FF);
    step(1, 0, 0, 1, 32'h11223344, 32'h11223345, FF);
    step(1, 0, 0, 1, 32'hAABBCCDD, 32'h0, FF);
    step(1, 0, 0, 1, 32'h55555555, 32'h0, FF);
    chk("cap_gold keep", cg2, 32'h11223344);
    chk("cap_gate keep", ct2, 32'h11223345);
    chk("cap_gold stop", cg1, 32'h11223344);
    chk("cap_gate stop", ct1, 32'h11223345);
    step(1, 1, 0, 0, 0, 0, FF);
    chk("cap_gold clear", cg2, 32'h0);
    chk("cap_gate clear", ct2, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
